mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- Load/store unit directly upstream of the byte-addressed data memory; consumes load/store requests from the execute stage and produces write-back results.
- Validates alignment and opcode, then generates a word-aligned memory access with byte enables and lane-replicated store data.
- Waits a fixed read latency, then extracts, sign- or zero-extends and returns load data through a valid/ready result port.
- Encodings: loads use funct3 LB=000, LH=001, LW=010, LBU=100, LHU=101; stores use funct3 SB=000, SH=001, SW=010.

Parameters:
READ_LATENCY, 1, cycles from the mem_en read cycle to mem_rdata valid; legal range 1..7.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
req_valid  input  1  execute stage presents a request.
req_ready  output  1  block accepts a request; transfer occurs when req_valid and req_ready are both high at a rising edge.
req_load  input  1  request is a load.
req_store  input  1  request is a store.
req_funct3  input  3  access size/sign code.
req_addr  input  32  byte address.
req_wdata  input  32  store data, LSB-aligned.
req_rd  input  5  load destination register.
mem_en  output  1  memory access strobe, one cycle per access.
mem_we  output  4  byte write enables; 0000 indicates a read.
mem_addr  output  32  word address {addr[31:2],2'b00}.
mem_wdata  output  32  lane-replicated store data.
mem_rdata  input  32  read word, valid READ_LATENCY cycles after the mem_en read cycle.
resp_valid  output  1  result available.
resp_ready  input  1  write-back stage accepts the result.
resp_data  output  32  formatted load data; 0 for stores and faults.
resp_rd  output  5  destination register.
resp_wen  output  1  register write required (successful load with rd != 0).
resp_misalign  output  1  misaligned access fault.
resp_illegal  output  1  illegal request fault.
resp_badaddr  output  32  faulting address; 0 if no fault.

Behaviour:
- States: IDLE, ACCESS, WAIT, RESP. req_ready = (state==IDLE) and not rst; it is combinational from state.
- Reset (asynchronous, at any point including mid-access): state goes to IDLE. All registered outputs and latches clear to 0 (mem_en=0, mem_we=0, resp_valid=0, all resp_* fields 0). An outstanding read is abandoned and its later mem_rdata is ignored.
- IDLE, on transfer: latch addr, wdata, funct3, rd, load/store.
  - Illegal request: both or neither of req_load/req_store set, load funct3 in {011,110,111}, or store funct3 >= 011. Go to RESP with resp_illegal=1.
  - Misaligned request (legal op only): halfword access with addr[0]=1, or word access with addr[1:0]!=00. Go to RESP with resp_misalign=1.
  - Faults take 1 cycle to resp_valid and never assert mem_en. resp_badaddr = latched address.
  - Otherwise go to ACCESS.
- ACCESS (exactly one cycle): mem_en=1.
  - Store write enables: SB gives 0001<<addr[1:0]; SH gives 0011<<addr[1:0]; SW gives 1111.
  - Store data: SB gives {4{wdata[7:0]}}; SH gives {2{wdata[15:0]}}; SW gives wdata.
  - Load: mem_we=0000, mem_wdata=0.
  - Next state: store goes to RESP; load goes to WAIT with a latency counter loaded to READ_LATENCY.
- WAIT: the counter decrements each cycle. In the cycle it reaches 1, capture mem_rdata and format it, then go to RESP.
  - Byte loads: select byte addr[1:0]; LB sign-extends, LBU zero-extends.
  - Halfword loads: select halfword addr[1]; LH sign-extends, LHU zero-extends.
  - LW passes the word through unchanged.
- RESP: resp_valid=1 and all resp_* fields held stable until resp_ready is high at an edge, then go to IDLE.
  - No new request is accepted in the same cycle as the handshake; back-to-back throughput is one request per (latency+1) cycles.
- Latency from the accepting edge to resp_valid: fault 1 cycle, store 2 cycles, load 2+READ_LATENCY cycles.
- resp_wen = load, no fault, and rd != 0. Stores set resp_wen=0, resp_data=0.
- req_* inputs are sampled only at the accept edge; changes afterwards have no effect.

Test Plan:
- SW addr=0x40, wdata=0xDEADBEEF -> one cycle with mem_en=1, mem_we=1111, mem_addr=0x40, mem_wdata=0xDEADBEEF; resp_valid 2 cycles after accept, resp_wen=0.
- SB addr=0x43, wdata=0x12345680; then LB addr=0x43 with mem_rdata=0x80000000 -> store uses mem_we=1000, mem_wdata=0x80808080; load returns resp_data=0xFFFFFF80; LBU at the same address returns 0x00000080.
- LH addr=0x42 with mem_rdata=0x8001ABCD -> resp_data=0xFFFF8001; LHU -> 0x00008001; resp_valid at accept+3 with READ_LATENCY=1, and at accept+5 with READ_LATENCY=3.
- LW addr=0x41 -> no mem_en, resp_misalign=1, resp_badaddr=0x41, resp_wen=0 at accept+1. Load funct3=011 -> resp_illegal=1. Load with rd=0 -> resp_wen=0.
- Hold resp_ready=0 for 5 cycles during RESP -> resp_* stable and req_ready=0 throughout; transfer on the first resp_ready=1 edge, req_ready=1 the following cycle.
- Assert rst during WAIT of an LW -> asynchronously state=IDLE and all outputs 0; mem_rdata returned after release produces no resp_valid; the next LW completes normally.

Source files
------------

// File: rtl/mem_lsu.sv
// Load/store unit sitting directly in front of the byte-addressed data memory.
// It checks each request, issues one word-aligned access with byte enables, and
// returns the formatted result through a valid/ready port.
//
// Handshakes: a transfer happens on a rising edge where both valid and ready are
// high. req_ready is high only in IDLE outside reset. resp_valid stays high and
// every resp_* field stays fixed until an edge where resp_ready is also high.
module mem_lsu #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_wen,
  output logic        resp_misalign,
  output logic        resp_illegal,
  output logic [31:0] resp_badaddr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY);

  state_t      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic        store_q, store_d;
  logic [2:0]  cnt_q, cnt_d;

  logic        mem_en_q, mem_en_d;
  logic [3:0]  mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [4:0]  resp_rd_q, resp_rd_d;
  logic        resp_wen_q, resp_wen_d;
  logic        resp_misalign_q, resp_misalign_d;
  logic        resp_illegal_q, resp_illegal_d;
  logic [31:0] resp_badaddr_q, resp_badaddr_d;

  // Opcode legality: exactly one of load/store, and a size code that exists.
  function automatic logic req_is_illegal(input logic ld, input logic st,
                                          input logic [2:0] f3);
    if (ld == st) return 1'b1;
    if (ld) return (f3 == 3'b011) || (f3[2:1] == 2'b11);
    return f3 >= 3'b011;
  endfunction

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic req_is_misaligned(input logic [2:0] f3,
                                             input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_we(input logic [2:0] f3,
                                          input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3,
                                             input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] format_load(input logic [2:0] f3,
                                              input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Next-state and next-output logic for the access sequence.
  always_comb begin
    state_d         = state_q;
    off_d           = off_q;
    funct3_d        = funct3_q;
    rd_d            = rd_q;
    store_d         = store_q;
    cnt_d           = cnt_q;
    mem_en_d        = 1'b0;
    mem_we_d        = 4'b0000;
    mem_addr_d      = 32'd0;
    mem_wdata_d     = 32'd0;
    resp_valid_d    = resp_valid_q;
    resp_data_d     = resp_data_q;
    resp_rd_d       = resp_rd_q;
    resp_wen_d      = resp_wen_q;
    resp_misalign_d = resp_misalign_q;
    resp_illegal_d  = resp_illegal_q;
    resp_badaddr_d  = resp_badaddr_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          off_d    = req_addr[1:0];
          funct3_d = req_funct3;
          rd_d     = req_rd;
          store_d  = req_store;
          resp_rd_d = req_rd;
          if (req_is_illegal(req_load, req_store, req_funct3)) begin
            state_d         = S_RESP;
            resp_valid_d    = 1'b1;
            resp_illegal_d  = 1'b1;
            resp_misalign_d = 1'b0;
            resp_badaddr_d  = req_addr;
            resp_data_d     = 32'd0;
            resp_wen_d      = 1'b0;
          end else if (req_is_misaligned(req_funct3, req_addr[1:0])) begin
            state_d         = S_RESP;
            resp_valid_d    = 1'b1;
            resp_illegal_d  = 1'b0;
            resp_misalign_d = 1'b1;
            resp_badaddr_d  = req_addr;
            resp_data_d     = 32'd0;
            resp_wen_d      = 1'b0;
          end else begin
            // Outputs are registered, so the ACCESS-cycle strobe is set up here.
            state_d    = S_ACCESS;
            mem_en_d   = 1'b1;
            mem_addr_d = {req_addr[31:2], 2'b00};
            if (req_store) begin
              mem_we_d    = store_we(req_funct3, req_addr[1:0]);
              mem_wdata_d = store_data(req_funct3, req_wdata);
            end
          end
        end
      end
      S_ACCESS: begin
        if (store_q) begin
          state_d         = S_RESP;
          resp_valid_d    = 1'b1;
          resp_data_d     = 32'd0;
          resp_wen_d      = 1'b0;
          resp_misalign_d = 1'b0;
          resp_illegal_d  = 1'b0;
          resp_badaddr_d  = 32'd0;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd1) begin
          state_d         = S_RESP;
          resp_valid_d    = 1'b1;
          resp_data_d     = format_load(funct3_q, off_q, mem_rdata);
          resp_wen_d      = rd_q != 5'd0;
          resp_misalign_d = 1'b0;
          resp_illegal_d  = 1'b0;
          resp_badaddr_d  = 32'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d         = S_IDLE;
          resp_valid_d    = 1'b0;
          resp_data_d     = 32'd0;
          resp_rd_d       = 5'd0;
          resp_wen_d      = 1'b0;
          resp_misalign_d = 1'b0;
          resp_illegal_d  = 1'b0;
          resp_badaddr_d  = 32'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, request latches and registered outputs; reset abandons any access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      off_q           <= 2'd0;
      funct3_q        <= 3'd0;
      rd_q            <= 5'd0;
      store_q         <= 1'b0;
      cnt_q           <= 3'd0;
      mem_en_q        <= 1'b0;
      mem_we_q        <= 4'd0;
      mem_addr_q      <= 32'd0;
      mem_wdata_q     <= 32'd0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= 32'd0;
      resp_rd_q       <= 5'd0;
      resp_wen_q      <= 1'b0;
      resp_misalign_q <= 1'b0;
      resp_illegal_q  <= 1'b0;
      resp_badaddr_q  <= 32'd0;
    end else begin
      state_q         <= state_d;
      off_q           <= off_d;
      funct3_q        <= funct3_d;
      rd_q            <= rd_d;
      store_q         <= store_d;
      cnt_q           <= cnt_d;
      mem_en_q        <= mem_en_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      resp_valid_q    <= resp_valid_d;
      resp_data_q     <= resp_data_d;
      resp_rd_q       <= resp_rd_d;
      resp_wen_q      <= resp_wen_d;
      resp_misalign_q <= resp_misalign_d;
      resp_illegal_q  <= resp_illegal_d;
      resp_badaddr_q  <= resp_badaddr_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE) && !rst;
  assign mem_en        = mem_en_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign resp_rd       = resp_rd_q;
  assign resp_wen      = resp_wen_q;
  assign resp_misalign = resp_misalign_q;
  assign resp_illegal  = resp_illegal_q;
  assign resp_badaddr  = resp_badaddr_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed cases with literal expectations, then random
// requests checked cycle by cycle against a behavioural model.
module tb_mem_lsu;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_load = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_wen;
  logic        resp_misalign;
  logic        resp_illegal;
  logic [31:0] resp_badaddr;

  mem_lsu #(.READ_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_wen(resp_wen), .resp_misalign(resp_misalign),
    .resp_illegal(resp_illegal), .resp_badaddr(resp_badaddr)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  bit hold_rr = 1'b0;

  typedef struct {
    bit          access;
    logic [3:0]  we;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    int          resp_at;
    logic [31:0] data;
    logic [4:0]  rd;
    bit          is_load;
    logic        wen;
    logic        mis;
    logic        ill;
    logic [31:0] bad;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [0:63];
  logic [31:0] dmem    [0:63];

  int          obs_lat, en_cnt, rv_cycles;
  logic [3:0]  last_we;
  logic [31:0] last_maddr, last_mwdata, last_data, last_bad;
  logic        last_wen, last_mis, last_ill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic exp_t model(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [4:0] rd);
    exp_t e;
    int nb, off, idx;
    bit legal;
    longint unsigned w, v;
    logic [7:0] b;
    e = '{default: 0};
    legal = (ld != st) && (ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2));
    nb  = 1 << int'(f3[1:0]);
    off = int'(addr[1:0]);
    idx = int'(addr[7:2]);
    e.is_load = ld;
    e.rd = rd;
    if (!legal) begin
      e.ill = 1'b1; e.bad = addr; e.resp_at = 1;
    end else if ((off % nb) != 0) begin
      e.mis = 1'b1; e.bad = addr; e.resp_at = 1;
    end else if (st) begin
      e.access = 1'b1; e.resp_at = 2; e.maddr = {addr[31:2], 2'b00};
      for (int i = 0; i < 4; i++) begin
        b = wd[8*(i % nb) +: 8];
        e.mwdata[8*i +: 8] = b;
        if (i >= off && i < off + nb) begin
          e.we[i] = 1'b1;
          ref_mem[idx][8*i +: 8] = b;
        end
      end
    end else begin
      e.access = 1'b1; e.resp_at = 2 + LAT; e.maddr = {addr[31:2], 2'b00};
      w = longint'(ref_mem[idx]);
      v = (w >> (8 * off)) & ((64'd1 << (8 * nb)) - 64'd1);
      if (f3 < 3'd4 && nb < 4 && v >= (64'd1 << (8 * nb - 1)))
        v = v - (64'd1 << (8 * nb));
      e.data = v[31:0];
      e.wen = (rd != 5'd0);
    end
    return e;
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    int age;
    logic [31:0] word;
    age = -1;
    word = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_en && mem_we != 4'd0)
        for (int i = 0; i < 4; i++)
          if (mem_we[i]) dmem[mem_addr[7:2]][8*i +: 8] = mem_wdata[8*i +: 8];
      if (age >= 0) age++;
      if (mem_en && mem_we == 4'd0) begin
        word = dmem[mem_addr[7:2]];
        age = 0;
      end
      mem_rdata = (age == LAT) ? word : $urandom();
    end
  end

  // ---------------- resp_ready driver ----------------
  initial forever begin
    @(posedge clk);
    #2;
    if (!hold_rr) resp_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- scoreboard / compare process ----------------
  initial begin
    int k;
    bit exp_rv;
    k = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        continue;
      end
      if (exp_q.size() == 0) begin
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        chk("idle_mem_en", 32'(mem_en), 32'd0);
        chk("idle_resp_valid", 32'(resp_valid), 32'd0);
        if (req_valid) begin
          exp_q.push_back(model(req_load, req_store, req_funct3, req_addr, req_wdata, req_rd));
          k = 0; obs_lat = 0; en_cnt = 0; rv_cycles = 0;
        end
      end else begin
        k++;
        chk("busy_req_ready", 32'(req_ready), 32'd0);
        chk("mem_en", 32'(mem_en), 32'(exp_q[0].access && k == 1));
        if (mem_en) begin
          en_cnt++;
          chk("mem_we", 32'(mem_we), 32'(exp_q[0].we));
          chk("mem_addr", mem_addr, exp_q[0].maddr);
          chk("mem_wdata", mem_wdata, exp_q[0].mwdata);
          last_we = mem_we; last_maddr = mem_addr; last_mwdata = mem_wdata;
        end
        if (resp_valid && obs_lat == 0) obs_lat = k;
        exp_rv = (k >= exp_q[0].resp_at);
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        if (exp_rv) begin
          rv_cycles++;
          chk("resp_data", resp_data, exp_q[0].data);
          chk("resp_wen", 32'(resp_wen), 32'(exp_q[0].wen));
          chk("resp_misalign", 32'(resp_misalign), 32'(exp_q[0].mis));
          chk("resp_illegal", 32'(resp_illegal), 32'(exp_q[0].ill));
          chk("resp_badaddr", resp_badaddr, exp_q[0].bad);
          if (exp_q[0].is_load && !exp_q[0].mis && !exp_q[0].ill)
            chk("resp_rd", 32'(resp_rd), 32'(exp_q[0].rd));
          last_data = resp_data; last_wen = resp_wen; last_mis = resp_misalign;
          last_ill = resp_illegal; last_bad = resp_badaddr;
          if (resp_ready) void'(exp_q.pop_front());
        end else if (k > 60) begin
          total++; bad++;
          $display("FAIL resp_timeout actual=no_response required=resp_valid at %0t", $time);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic ld, input logic st, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    int n;
    n = 0;
    @(posedge clk);
    #2;
    req_valid = 1'b1; req_load = ld; req_store = st; req_funct3 = f3;
    req_addr = addr; req_wdata = wd; req_rd = rd;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 200);
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout actual=req_ready_low required=accept at %0t", $time);
    end
    @(posedge clk);
    #2;
    // Scramble the request bus after the accept edge; it must be ignored.
    req_valid = 1'b0; req_load = 1'($urandom()); req_store = 1'($urandom());
    req_funct3 = 3'($urandom()); req_addr = $urandom(); req_wdata = $urandom();
    req_rd = 5'($urandom());
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL done_timeout actual=busy required=idle at %0t", $time);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] w);
    dmem[idx] = w;
    ref_mem[idx] = w;
  endtask

  // ---------------- main sequence ----------------
  logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    for (int i = 0; i < 64; i++) preload(i, 32'd0);
    hold_rr = 1'b1;
    resp_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // SW 0x40
    send(1'b0, 1'b1, 3'd2, 32'h40, 32'hDEADBEEF, 5'd3);
    wait_done();
    chk("sw_we", 32'(last_we), 32'hF);
    chk("sw_addr", last_maddr, 32'h40);
    chk("sw_wdata", last_mwdata, 32'hDEADBEEF);
    chk("sw_lat", 32'(obs_lat), 32'd2);
    chk("sw_wen", 32'(last_wen), 32'd0);
    chk("sw_en_cnt", 32'(en_cnt), 32'd1);

    // SB 0x43 then LB/LBU 0x43
    send(1'b0, 1'b1, 3'd0, 32'h43, 32'h12345680, 5'd3);
    wait_done();
    chk("sb_we", 32'(last_we), 32'b1000);
    chk("sb_wdata", last_mwdata, 32'h80808080);
    send(1'b1, 1'b0, 3'd0, 32'h43, 32'd0, 5'd4);
    wait_done();
    chk("lb_data", last_data, 32'hFFFFFF80);
    chk("lb_wen", 32'(last_wen), 32'd1);
    send(1'b1, 1'b0, 3'd4, 32'h43, 32'd0, 5'd4);
    wait_done();
    chk("lbu_data", last_data, 32'h00000080);

    // LH/LHU 0x42
    preload(16, 32'h8001ABCD);
    send(1'b1, 1'b0, 3'd1, 32'h42, 32'd0, 5'd9);
    wait_done();
    chk("lh_data", last_data, 32'hFFFF8001);
    chk("lh_lat", 32'(obs_lat), 32'(2 + LAT));
    send(1'b1, 1'b0, 3'd5, 32'h42, 32'd0, 5'd9);
    wait_done();
    chk("lhu_data", last_data, 32'h00008001);

    // Faults and rd=0
    send(1'b1, 1'b0, 3'd2, 32'h41, 32'd0, 5'd6);
    wait_done();
    chk("mis_flag", 32'(last_mis), 32'd1);
    chk("mis_bad", last_bad, 32'h41);
    chk("mis_wen", 32'(last_wen), 32'd0);
    chk("mis_lat", 32'(obs_lat), 32'd1);
    chk("mis_en_cnt", 32'(en_cnt), 32'd0);
    send(1'b1, 1'b0, 3'd3, 32'h40, 32'd0, 5'd6);
    wait_done();
    chk("ill_flag", 32'(last_ill), 32'd1);
    send(1'b1, 1'b0, 3'd2, 32'h40, 32'd0, 5'd0);
    wait_done();
    chk("rd0_wen", 32'(last_wen), 32'd0);
    chk("rd0_data", last_data, 32'h8001ABCD);

    // Hold resp_ready low for five cycles of resp_valid
    preload(17, 32'hCAFEF00D);
    @(posedge clk);
    resp_ready = 1'b0;
    send(1'b1, 1'b0, 3'd2, 32'h44, 32'd0, 5'd5);
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!resp_valid && n < 50);
    end
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 resp_ready = 1'b1;
    @(posedge clk);
    #3;
    chk("hs_req_ready", 32'(req_ready), 32'd1);
    chk("hs_resp_valid", 32'(resp_valid), 32'd0);
    chk("hold_rv_cycles", 32'(rv_cycles), 32'd7);
    chk("hold_data", last_data, 32'hCAFEF00D);

    // Reset in the middle of a load's WAIT phase
    preload(32, 32'h11223344);
    send(1'b1, 1'b0, 3'd2, 32'h80, 32'd0, 5'd7);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_req_ready", 32'(req_ready), 32'd0);
    chk("arst_mem_en", 32'(mem_en), 32'd0);
    chk("arst_mem_we", 32'(mem_we), 32'd0);
    chk("arst_resp_valid", 32'(resp_valid), 32'd0);
    chk("arst_resp_data", resp_data, 32'd0);
    chk("arst_resp_rd", 32'(resp_rd), 32'd0);
    chk("arst_badaddr", resp_badaddr, 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("arst_no_resp", 32'(resp_valid), 32'd0);
    send(1'b1, 1'b0, 3'd2, 32'h80, 32'd0, 5'd7);
    wait_done();
    chk("post_rst_data", last_data, 32'h11223344);
    chk("post_rst_lat", 32'(obs_lat), 32'(2 + LAT));

    // Random traffic
    hold_rr = 1'b0;
    for (int t = 0; t < 200; t++) begin
      logic ld, st;
      logic [2:0] f3;
      logic [31:0] a;
      ld = 1'($urandom_range(0, 1));
      st = !ld;
      if ($urandom_range(0, 9) == 0) st = ld;
      if ($urandom_range(0, 9) < 8)
        f3 = ld ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      else
        f3 = 3'($urandom_range(0, 7));
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~32'((1 << int'(f3[1:0])) - 1);
      send(ld, st, f3, a, $urandom(), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 1) == 0) wait_done();
    end
    wait_done();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
